// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types for the pipeline hazard controller (state enum, register-zero constant)
package cpu_types_pkg;
  typedef enum logic [2:0] {RUN, DWAIT, REDIR, DRAIN, HALTED} hzstate_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/hazard_if.sv
// hazard_if: bundle of hazard controller outputs; hc modport is the controller's view
interface hazard_if;
  logic pc_en, pc_redirect, halt;
  logic ifid_freeze, idex_freeze, exmem_freeze, memwb_freeze;
  logic ifid_flush, idex_flush, exmem_flush;
  modport hc(output pc_en, pc_redirect, halt, ifid_freeze, idex_freeze, exmem_freeze,
             memwb_freeze, ifid_flush, idex_flush, exmem_flush);
endinterface

// File: rtl/loaduse_detect.sv
// loaduse_detect: load in EX writes a register read by the instruction in ID (ports: dren, wsel, rs, rt -> stall)
module loaduse_detect
  import cpu_types_pkg::*;
(
  input  logic       dren,
  input  logic [4:0] wsel,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  output logic       stall
);
  assign stall = dren && (wsel != REG_ZERO) && (wsel == rs || wsel == rt);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush controller; memory handshakes and stage info in, latch freeze/flush, PC enable/redirect and sticky halt out
module pipeline_hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int HALT_DRAIN = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ihit,
  input  logic       dhit,
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  input  logic       idex_dREN,
  input  logic [4:0] idex_wsel,
  input  logic       exmem_dREN,
  input  logic       exmem_dWEN,
  input  logic       exmem_redirect,
  input  logic       exmem_halt,
  output logic       pc_en,
  output logic       pc_redirect,
  output logic       ifid_freeze,
  output logic       idex_freeze,
  output logic       exmem_freeze,
  output logic       memwb_freeze,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       exmem_flush,
  output logic       halt
);
  hzstate_t st, nxt;
  logic [7:0] cnt, cnt_n;
  logic lu, dwait_c;
  logic pe, pr, hl, fz_if, fz_ie, fz_em, fz_mw, fl_if, fl_ie, fl_em;
  hazard_if h();

  loaduse_detect u_lu (.dren(idex_dREN), .wsel(idex_wsel), .rs(ifid_rs), .rt(ifid_rt), .stall(lu));

  // DWAIT keeps waiting on dhit alone, so halt commit is blocked until the access finishes
  assign dwait_c = (exmem_dREN || exmem_dWEN || st == DWAIT) && !dhit;

  always_comb begin
    nxt = st;
    cnt_n = cnt;
    {pe, pr, hl, fz_if, fz_ie, fz_em, fz_mw, fl_if, fl_ie, fl_em} = '0;
    if (st == HALTED) begin
      {hl, fz_if, fz_ie, fz_em, fz_mw} = '1;
    end else if (st == DRAIN) begin
      {fz_if, fz_ie, fz_em, fz_mw} = '1;
      nxt = (cnt == 8'd0) ? HALTED : DRAIN;
      cnt_n = (cnt == 8'd0) ? cnt : cnt - 8'd1;
    end else if (st == REDIR) begin
      // IF/ID holds a wrong-path instruction while waiting, so ID/EX keeps getting bubbles
      pr = 1'b1;
      fl_ie = 1'b1;
      pe = ihit;
      fl_if = ihit;
      fz_if = !ihit;
      nxt = ihit ? RUN : REDIR;
    end else if (exmem_halt && !dwait_c) begin
      {fl_if, fl_ie, fl_em} = '1;
      nxt = DRAIN;
      cnt_n = 8'(HALT_DRAIN - 1);
    end else if (dwait_c) begin
      {fz_if, fz_ie, fz_em, fz_mw} = '1;
      nxt = DWAIT;
    end else if (exmem_redirect) begin
      pr = 1'b1;
      {fl_ie, fl_em} = '1;
      pe = ihit;
      fl_if = ihit;
      fz_if = !ihit;
      nxt = ihit ? RUN : REDIR;
    end else begin
      nxt = RUN;
      pe = ihit && !lu;
      fz_if = !ihit || lu;
      fl_ie = !ihit || lu;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st <= RUN;
      cnt <= '0;
    end else begin
      st <= nxt;
      cnt <= cnt_n;
    end
  end

  // outputs are quiet while reset is held; a flush always beats a freeze on the same latch
  assign h.pc_en        = !RST && pe;
  assign h.pc_redirect  = !RST && pr;
  assign h.halt         = !RST && hl;
  assign h.ifid_flush   = !RST && fl_if;
  assign h.idex_flush   = !RST && fl_ie;
  assign h.exmem_flush  = !RST && fl_em;
  assign h.ifid_freeze  = !RST && fz_if && !fl_if;
  assign h.idex_freeze  = !RST && fz_ie && !fl_ie;
  assign h.exmem_freeze = !RST && fz_em && !fl_em;
  assign h.memwb_freeze = !RST && fz_mw;

  assign pc_en        = h.pc_en;
  assign pc_redirect  = h.pc_redirect;
  assign halt         = h.halt;
  assign ifid_flush   = h.ifid_flush;
  assign idex_flush   = h.idex_flush;
  assign exmem_flush  = h.exmem_flush;
  assign ifid_freeze  = h.ifid_freeze;
  assign idex_freeze  = h.idex_freeze;
  assign exmem_freeze = h.exmem_freeze;
  assign memwb_freeze = h.memwb_freeze;
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the five-stage pipelined MIPS core. Watches memory handshakes (ihit/dhit), the ID/EX and EX/MEM latch outputs and the IF/ID source registers, and drives the per-latch freeze/flush controls plus PC enable/redirect. Holds the registered state that survives multi-cycle waits: pending redirect, halt drain and sticky halt.

## Interface
- HALT_DRAIN, default 2: cycles after halt commits at MEM before `halt` asserts, covering the MEM/WB write and the dcache handoff.
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- ihit  in  1  instruction fetch complete this cycle.
- dhit  in  1  data access complete this cycle.
- ifid_rs, ifid_rt  in  5 each  source registers of the instruction in ID.
- idex_dREN  in  1  instruction in EX is a load.
- idex_wsel  in  5  destination of the instruction in EX.
- exmem_dREN, exmem_dWEN  in  1 each  MEM-stage data access.
- exmem_redirect  in  1  taken branch/jump/jr resolved at MEM (brn&zero | bne&!zero | jmp | jr).
- exmem_halt  in  1  halt instruction at MEM.
- pc_en  out  1  PC may update.
- pc_redirect  out  1  PC loads the MEM-stage target instead of npc.
- ifid_freeze, idex_freeze, exmem_freeze, memwb_freeze  out  1 each.
- ifid_flush, idex_flush, exmem_flush  out  1 each.
- halt  out  1  sticky; core stopped.

## Operation
- States: RUN, DWAIT, REDIR, DRAIN, HALTED. State, drain counter and saved redirect are registered; all outputs are combinational from state plus inputs.
- Priority each cycle, highest first: HALTED, DRAIN, halt commit, data wait, redirect, load-use.
- RUN:
  - exmem_halt & (no data access or dhit): flush IF/ID, ID/EX, EX/MEM; pc_en=0; go DRAIN, counter=HALT_DRAIN-1.
  - (exmem_dREN|exmem_dWEN) & !dhit: freeze all four latches, pc_en=0; go DWAIT.
  - exmem_redirect & ihit: pc_en=1, pc_redirect=1, flush IF/ID, ID/EX, EX/MEM; stay RUN.
  - exmem_redirect & !ihit: freeze IF/ID and PC; flush ID/EX and EX/MEM; go REDIR.
  - Load-use: idex_dREN & idex_wsel!=0 & (idex_wsel==ifid_rs | idex_wsel==ifid_rt). Freeze PC and IF/ID, flush ID/EX; one bubble only.
  - !ihit with no other event: freeze PC and IF/ID, flush ID/EX; later stages advance.
- DWAIT: freeze all latches and PC until dhit. On dhit, the RUN rules are evaluated in the same cycle (MEM advances), then return to RUN.
- REDIR: pc_redirect=1; PC and IF/ID frozen until ihit. On ihit: pc_en=1, flush IF/ID, go RUN. The MEM-stage target is held by exmem_freeze=0 and a flushed EX/MEM; the PC block latches the target on entry.
- DRAIN: all latches frozen, pc_en=0; count down; at 0 go HALTED.
- HALTED: halt=1; all latches frozen; pc_en=0; only RST leaves.
- A flush of a latch overrides its freeze.

## Timing
- Reset: state=RUN, counter=0, halt=0. All freezes=0, all flushes=0, pc_en=0, pc_redirect=0 while RST is high.
- The first cycle after RST falls behaves as RUN.
- Load-use costs exactly 1 cycle when ihit=1.
- Redirect costs 3 squashed instructions plus any cycles ihit stays low.
- halt rises exactly HALT_DRAIN+1 cycles after the halt-commit edge; HALT_DRAIN=1 gives a 2-cycle latency.
- Simultaneous events:
  - exmem_redirect together with a load-use: redirect wins and the ID/EX flush covers the hazard.
  - exmem_halt together with !dhit: DWAIT first, then halt.
  - RST mid-DWAIT, REDIR or DRAIN returns to RUN immediately and asynchronously.

## Structure
- cpu_types_pkg gains the `hzstate_t` enum (RUN, DWAIT, REDIR, DRAIN, HALTED) and the constant `REG_ZERO` (5'd0).
- One natural sub-module, `loaduse_detect`: combinational compare of idex_wsel against ifid_rs/rt, returning a single stall bit.
- A `hazard_if` interface with a `hc` modport bundles the ports.

## Test plan
- **Load-use:** lw $3 in EX, ID reads $3, ihit=1 -> one cycle with pc_en=0, ifid_freeze=1, idex_flush=1; next cycle normal. Same case with wsel=0 -> no stall.
- **Data wait:** dREN at MEM, dhit low 4 cycles -> state DWAIT, all freezes=1 for 4 cycles; release on the dhit cycle.
- **Redirect, slow fetch:** exmem_redirect with ihit low 3 cycles -> idex/exmem flushed in the first cycle; pc_redirect held through REDIR; pc_en and ifid_flush pulse on the ihit cycle.
- **Redirect plus load-use:** both in the same cycle -> pc_redirect=1, all three flushes=1, no extra stall cycle.
- **Halt behind a store:** exmem_halt & dWEN, dhit after 2 cycles, HALT_DRAIN=2 -> DWAIT for 2 cycles, then halt=1 three cycles later, sticky.
- **Reset mid-operation:** RST asserted while in DRAIN -> halt=0 and all outputs 0 asynchronously; RUN after release.
